// File: rtl/dw_conv_win_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// dw_conv_win_gen_pipe_if
// Stream bundle between the DW line buffer, the window generator and the DW
// MAC array.
//   data_in   : K-row pixel column for CH channels, pixel (c,r) at
//               [(c*K+r)*DW +: DW], r=0 is the top row
//   valid_in  : column valid
//   ready_in  : window generator accepts the column this cycle
//   win_out   : KxK window per channel, pixel (c,r,k) at
//               [(c*K*K+r*K+k)*DW +: DW], k=K-1 is the newest column
//   valid_out : win_out valid
//   ready_out : downstream accepts the window
//   eol_out   : qualifies valid_out, last window of the current row
// Modports:
//   slave  - the window generator itself
//   master - the environment (line buffer upstream, MAC array downstream)
// -----------------------------------------------------------------------------
interface dw_conv_win_gen_pipe_if #(
  parameter int CH = 18,
  parameter int DW = 8,
  parameter int K  = 3
) ();
  logic [CH*K*DW-1:0]   data_in;
  logic                 valid_in;
  logic                 ready_in;
  logic [CH*K*K*DW-1:0] win_out;
  logic                 valid_out;
  logic                 ready_out;
  logic                 eol_out;

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, win_out, valid_out, eol_out
  );

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, win_out, valid_out, eol_out
  );
endinterface

// File: rtl/dw_conv_win_gen_pipe.sv
// -----------------------------------------------------------------------------
// dw_conv_win_gen_pipe
// Depthwise-convolution window generator. Takes one K-row pixel column per
// cycle for CH channels and builds a registered KxK sliding window per
// channel, with horizontal stride, row tracking and valid/ready backpressure.
//
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : dw_conv_win_gen_pipe_if.slave (column in, window out, eol)
//
// Optional feature macro: ZERO_PAD_EN
//   defined   -> P=(K-1)/2; the cleared history supplies the left padding and
//                a FLUSH phase shifts in P zero columns on the right ("same")
//   undefined -> P=0; only fully-populated ("valid") windows, no FLUSH logic
// -----------------------------------------------------------------------------
module dw_conv_win_gen_pipe #(
  parameter int CH     = 18,
  parameter int DW     = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 32,
  parameter int STRIDE = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  dw_conv_win_gen_pipe_if.slave bus
);

`ifdef ZERO_PAD_EN
  localparam int P = (K - 1) / 2;
`else
  localparam int P = 0;
`endif

  localparam int LANES = CH * K;
  localparam int WIN_W = CH * K * K * DW;
  localparam int HW    = (K > 1) ? LANES * (K - 1) * DW : 1;
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_ROW_END = 2'd2;

  // First input column whose shift completes a window (padded index >= K-1).
  localparam logic [CW-1:0] FIRST_COL  = CW'(K - 1 - P);
  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(STRIDE - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_col_cnt;
  logic [PW-1:0]    r_phase;
  // Only the newest K-1 columns are kept: the oldest tap of a window is
  // shifted out by the very next shift, and every produced window is
  // captured whole into r_win.
  logic [HW-1:0]    r_hist;
  logic [WIN_W-1:0] r_win;
  logic             r_valid_out;
  logic             r_eol_out;

  logic             w_out_free;
  logic             w_accept;
  logic             w_flush_shift;
  logic             w_shift;
  logic             w_eligible;
  logic             w_produce;
  logic             w_row_last;
  logic [LANES*DW-1:0] w_col_src;
  logic [WIN_W-1:0] w_shift_next;
  logic [HW-1:0]    w_hist_next;

  // Output slot is free when empty or being drained this cycle.
  assign w_out_free = !r_valid_out || bus.ready_out;
  assign w_accept   = (r_state == S_RUN) && bus.valid_in && w_out_free;

`ifdef ZERO_PAD_EN
  localparam int FW = (P > 1) ? $clog2(P) : 1;
  localparam logic [FW-1:0] LAST_FLUSH = FW'((P > 0) ? P - 1 : 0);

  logic [FW-1:0] r_flush_cnt;

  assign w_flush_shift = (r_state == S_FLUSH) && w_out_free;
  assign w_col_src     = w_flush_shift ? '0 : bus.data_in;
  assign w_row_last    = (P == 0) ? (w_accept && (r_col_cnt == LAST_COL))
                                  : (w_flush_shift && (r_flush_cnt == LAST_FLUSH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flush_cnt <= '0;
    end else if (r_state == S_ROW_END) begin
      r_flush_cnt <= '0;
    end else if (w_flush_shift) begin
      r_flush_cnt <= r_flush_cnt + FW'(1);
    end
  end
`else
  assign w_flush_shift = 1'b0;
  assign w_col_src     = bus.data_in;
  assign w_row_last    = w_accept && (r_col_cnt == LAST_COL);
`endif

  assign w_shift    = w_accept || w_flush_shift;
  // Flush shifts are always past the left edge, so always eligible.
  assign w_eligible = w_flush_shift || (r_col_cnt >= FIRST_COL);
  assign w_produce  = w_shift && w_eligible && (r_phase == '0);

  // Post-shift window: taps move toward k=0, the new column lands at k=K-1.
  genvar gi, gk;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      for (gk = 0; gk < K; gk++) begin : g_tap
        if (gk == K - 1) begin : g_new
          assign w_shift_next[(gi*K+gk)*DW +: DW] = w_col_src[gi*DW +: DW];
        end else begin : g_old
          assign w_shift_next[(gi*K+gk)*DW +: DW]     = r_hist[(gi*(K-1)+gk)*DW +: DW];
          assign w_hist_next[(gi*(K-1)+gk)*DW +: DW] = w_shift_next[(gi*K+gk+1)*DW +: DW];
        end
      end
    end
    if (K == 1) begin : g_k1
      assign w_hist_next = '0;
    end
  endgenerate

  // Row state machine and column counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_RUN;
      r_col_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (r_col_cnt == LAST_COL) begin
              r_state <= (P == 0) ? S_ROW_END : S_FLUSH;
            end else begin
              r_col_cnt <= r_col_cnt + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (w_row_last) begin
            r_state <= S_ROW_END;
          end
        end
        S_ROW_END: begin
          r_state   <= S_RUN;
          r_col_cnt <= '0;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Stride phase advances on every window-eligible shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
    end else if (r_state == S_ROW_END) begin
      r_phase <= '0;
    end else if (w_shift && w_eligible) begin
      r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
    end
  end

  // Column history; cleared between rows so the next row starts from zeros
  // (which is also the left padding when P > 0).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist <= '0;
    end else if (r_state == S_ROW_END) begin
      r_hist <= '0;
    end else if (w_shift) begin
      r_hist <= w_hist_next;
    end
  end

  // Output register: a new window can replace one being handed off in the
  // same cycle, giving one window per cycle back to back.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win       <= '0;
      r_valid_out <= 1'b0;
      r_eol_out   <= 1'b0;
    end else if (w_produce) begin
      r_win       <= w_shift_next;
      r_valid_out <= 1'b1;
      r_eol_out   <= w_row_last;
    end else if (bus.ready_out) begin
      r_valid_out <= 1'b0;
      r_eol_out   <= 1'b0;
    end
  end

  assign bus.ready_in  = (r_state == S_RUN) && w_out_free;
  assign bus.win_out   = r_win;
  assign bus.valid_out = r_valid_out;
  assign bus.eol_out   = r_eol_out;

endmodule

// File: tb/tb_dw_conv_win_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_dw_conv_win_gen_pipe
// Directed bench for dw_conv_win_gen_pipe. Two instances with CH=2, K=3:
//   dut_a : IMG_W=8, STRIDE=1
//   dut_b : IMG_W=9, STRIDE=2
// Pixel value for column value v in lane (c*K+r) is v + 16*lane, so lane and
// tap ordering are both visible. Pad columns are all-zero in every lane.
// Each step drives inputs just after the rising edge, samples on the falling
// edge and prints one line only when a step disagrees.
// Build with ZERO_PAD_EN defined to run the padded-mode vectors instead.
// -----------------------------------------------------------------------------
module tb_dw_conv_win_gen_pipe;
  localparam int CH    = 2;
  localparam int DW    = 8;
  localparam int K     = 3;
  localparam int LANES = CH * K;
  localparam int CWID  = CH * K * DW;
  localparam int WW    = CH * K * K * DW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dw_conv_win_gen_pipe_if #(.CH(CH), .DW(DW), .K(K)) a_if ();
  dw_conv_win_gen_pipe_if #(.CH(CH), .DW(DW), .K(K)) b_if ();

  dw_conv_win_gen_pipe #(.CH(CH), .DW(DW), .K(K), .IMG_W(8), .STRIDE(1)) dut_a (
    .clk (clk),
    .rstn(rstn),
    .bus (a_if)
  );

  dw_conv_win_gen_pipe #(.CH(CH), .DW(DW), .K(K), .IMG_W(9), .STRIDE(2)) dut_b (
    .clk (clk),
    .rstn(rstn),
    .bus (b_if)
  );

  typedef struct {
    int sel;                   // 0 = dut_a, 1 = dut_b
    int vin, col, ro;          // valid_in, column value (-1 = zeros), ready_out
    int e_rin, e_v;            // expected ready_in, valid_out
    int w0, w1, w2;            // expected window columns k=0..2 (-1 = pad zero)
    int e_eol;                 // expected eol_out (when valid)
    int tid;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [DW-1:0] pix(input int v, input int lane);
    if (v < 0) return '0;
    return DW'(v + 16 * lane);
  endfunction

  function automatic logic [CWID-1:0] mk_col(input int v);
    logic [CWID-1:0] c;
    c = '0;
    for (int l = 0; l < LANES; l++) c[l*DW +: DW] = pix(v, l);
    return c;
  endfunction

  function automatic logic [WW-1:0] mk_win(input int a, input int b, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      w[(l*K+0)*DW +: DW] = pix(a, l);
      w[(l*K+1)*DW +: DW] = pix(b, l);
      w[(l*K+2)*DW +: DW] = pix(c, l);
    end
    return w;
  endfunction

  function automatic vec_t mkv(input int sel, input int vin, input int col, input int ro,
                               input int e_rin, input int e_v, input int w0, input int w1,
                               input int w2, input int e_eol, input int tid);
    vec_t r;
    r.sel = sel; r.vin = vin; r.col = col; r.ro = ro;
    r.e_rin = e_rin; r.e_v = e_v; r.w0 = w0; r.w1 = w1; r.w2 = w2;
    r.e_eol = e_eol; r.tid = tid;
    return r;
  endfunction

  task automatic idle_inputs();
    a_if.valid_in = 1'b0; a_if.ready_out = 1'b1; a_if.data_in = '0;
    b_if.valid_in = 1'b0; b_if.ready_out = 1'b1; b_if.data_in = '0;
  endtask

  // One clock step on the selected instance with a single comparison.
  task automatic step(input int sel, input int vin, input int col, input int ro,
                      input int e_rin, input int e_v, input int w0, input int w1,
                      input int w2, input int e_eol, input string name);
    logic [WW-1:0] exp_w, got_w;
    logic got_rin, got_v, got_eol;
    bit ok;
    idle_inputs();
    if (sel == 0) begin
      a_if.valid_in = (vin != 0); a_if.ready_out = (ro != 0); a_if.data_in = mk_col(col);
    end else begin
      b_if.valid_in = (vin != 0); b_if.ready_out = (ro != 0); b_if.data_in = mk_col(col);
    end
    @(negedge clk);
    if (sel == 0) begin
      got_rin = a_if.ready_in; got_v = a_if.valid_out; got_eol = a_if.eol_out; got_w = a_if.win_out;
    end else begin
      got_rin = b_if.ready_in; got_v = b_if.valid_out; got_eol = b_if.eol_out; got_w = b_if.win_out;
    end
    exp_w = mk_win(w0, w1, w2);
    ok = (got_rin == (e_rin != 0)) && (got_v == (e_v != 0)) &&
         ((e_v == 0) || ((got_w == exp_w) && (got_eol == (e_eol != 0))));
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got ready_in=%0b valid_out=%0b eol=%0b win=%h, want ready_in=%0b valid_out=%0b eol=%0b win=%h",
                  name, got_rin, got_v, got_eol, got_w, e_rin != 0, e_v != 0, e_eol != 0, exp_w);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string name);
    bit ok;
    ok = !a_if.valid_out && !a_if.eol_out && (a_if.win_out == '0) &&
         !b_if.valid_out && !b_if.eol_out && (b_if.win_out == '0);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got a(valid=%0b eol=%0b win=%h) b(valid=%0b eol=%0b win=%h), want all zero",
                  name, a_if.valid_out, a_if.eol_out, a_if.win_out,
                  b_if.valid_out, b_if.eol_out, b_if.win_out);
  endtask

  initial begin
`ifdef ZERO_PAD_EN
    // Padded, dut_a: 8 windows, first {P,0,1}, last {6,7,P} with eol; FLUSH holds ready_in low.
    tbl.push_back(mkv(0, 1,  0, 1, 1, 0, -1, -1, -1, 0, 5));
    tbl.push_back(mkv(0, 1,  1, 1, 1, 0, -1, -1, -1, 0, 5));
    tbl.push_back(mkv(0, 1,  2, 1, 1, 1, -1,  0,  1, 0, 5));
    tbl.push_back(mkv(0, 1,  3, 1, 1, 1,  0,  1,  2, 0, 5));
    tbl.push_back(mkv(0, 1,  4, 1, 1, 1,  1,  2,  3, 0, 5));
    tbl.push_back(mkv(0, 1,  5, 1, 1, 1,  2,  3,  4, 0, 5));
    tbl.push_back(mkv(0, 1,  6, 1, 1, 1,  3,  4,  5, 0, 5));
    tbl.push_back(mkv(0, 1,  7, 1, 1, 1,  4,  5,  6, 0, 5));
    tbl.push_back(mkv(0, 0, -1, 1, 0, 1,  5,  6,  7, 0, 5));
    tbl.push_back(mkv(0, 0, -1, 1, 0, 1,  6,  7, -1, 1, 5));
    tbl.push_back(mkv(0, 0, -1, 1, 1, 0, -1, -1, -1, 0, 5));
    // Padded, dut_b (IMG_W=9, STRIDE=2): {P,0,1},{1,2,3},{3,4,5},{5,6,7},{7,8,P}.
    tbl.push_back(mkv(1, 1,  0, 1, 1, 0, -1, -1, -1, 0, 6));
    tbl.push_back(mkv(1, 1,  1, 1, 1, 0, -1, -1, -1, 0, 6));
    tbl.push_back(mkv(1, 1,  2, 1, 1, 1, -1,  0,  1, 0, 6));
    tbl.push_back(mkv(1, 1,  3, 1, 1, 0, -1, -1, -1, 0, 6));
    tbl.push_back(mkv(1, 1,  4, 1, 1, 1,  1,  2,  3, 0, 6));
    tbl.push_back(mkv(1, 1,  5, 1, 1, 0, -1, -1, -1, 0, 6));
    tbl.push_back(mkv(1, 1,  6, 1, 1, 1,  3,  4,  5, 0, 6));
    tbl.push_back(mkv(1, 1,  7, 1, 1, 0, -1, -1, -1, 0, 6));
    tbl.push_back(mkv(1, 1,  8, 1, 1, 1,  5,  6,  7, 0, 6));
    tbl.push_back(mkv(1, 0, -1, 1, 0, 0, -1, -1, -1, 0, 6));
    tbl.push_back(mkv(1, 0, -1, 1, 0, 1,  7,  8, -1, 1, 6));
    tbl.push_back(mkv(1, 0, -1, 1, 1, 0, -1, -1, -1, 0, 6));
`else
    // Row 1 on dut_a (values = column index), then row 2 (+100) held off by ROW_END.
    tbl.push_back(mkv(0, 1,   0, 1, 1, 0,  -1,  -1,  -1, 0, 1));
    tbl.push_back(mkv(0, 1,   1, 1, 1, 0,  -1,  -1,  -1, 0, 1));
    tbl.push_back(mkv(0, 1,   2, 1, 1, 0,  -1,  -1,  -1, 0, 1));
    tbl.push_back(mkv(0, 1,   3, 1, 1, 1,   0,   1,   2, 0, 1));
    tbl.push_back(mkv(0, 1,   4, 1, 1, 1,   1,   2,   3, 0, 1));
    tbl.push_back(mkv(0, 1,   5, 1, 1, 1,   2,   3,   4, 0, 1));
    tbl.push_back(mkv(0, 1,   6, 1, 1, 1,   3,   4,   5, 0, 1));
    tbl.push_back(mkv(0, 1,   7, 1, 1, 1,   4,   5,   6, 0, 1));
    tbl.push_back(mkv(0, 1, 100, 1, 0, 1,   5,   6,   7, 1, 4));
    tbl.push_back(mkv(0, 1, 100, 1, 1, 0,  -1,  -1,  -1, 0, 4));
    tbl.push_back(mkv(0, 1, 101, 1, 1, 0,  -1,  -1,  -1, 0, 4));
    tbl.push_back(mkv(0, 1, 102, 1, 1, 0,  -1,  -1,  -1, 0, 4));
    tbl.push_back(mkv(0, 1, 103, 1, 1, 1, 100, 101, 102, 0, 4));
    tbl.push_back(mkv(0, 1, 104, 1, 1, 1, 101, 102, 103, 0, 4));
    tbl.push_back(mkv(0, 1, 105, 1, 1, 1, 102, 103, 104, 0, 4));
    tbl.push_back(mkv(0, 1, 106, 1, 1, 1, 103, 104, 105, 0, 4));
    tbl.push_back(mkv(0, 1, 107, 1, 1, 1, 104, 105, 106, 0, 4));
    tbl.push_back(mkv(0, 0,  -1, 1, 0, 1, 105, 106, 107, 1, 4));
    tbl.push_back(mkv(0, 0,  -1, 1, 1, 0,  -1,  -1,  -1, 0, 4));
    // dut_b, IMG_W=9, STRIDE=2: {0,1,2},{2,3,4},{4,5,6},{6,7,8}+eol.
    tbl.push_back(mkv(1, 1,  0, 1, 1, 0, -1, -1, -1, 0, 2));
    tbl.push_back(mkv(1, 1,  1, 1, 1, 0, -1, -1, -1, 0, 2));
    tbl.push_back(mkv(1, 1,  2, 1, 1, 0, -1, -1, -1, 0, 2));
    tbl.push_back(mkv(1, 1,  3, 1, 1, 1,  0,  1,  2, 0, 2));
    tbl.push_back(mkv(1, 1,  4, 1, 1, 0, -1, -1, -1, 0, 2));
    tbl.push_back(mkv(1, 1,  5, 1, 1, 1,  2,  3,  4, 0, 2));
    tbl.push_back(mkv(1, 1,  6, 1, 1, 0, -1, -1, -1, 0, 2));
    tbl.push_back(mkv(1, 1,  7, 1, 1, 1,  4,  5,  6, 0, 2));
    tbl.push_back(mkv(1, 1,  8, 1, 1, 0, -1, -1, -1, 0, 2));
    tbl.push_back(mkv(1, 0, -1, 1, 0, 1,  6,  7,  8, 1, 2));
    tbl.push_back(mkv(1, 0, -1, 1, 1, 0, -1, -1, -1, 0, 2));
`endif

    // Reset state.
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset_state");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sel, tbl[i].vin, tbl[i].col, tbl[i].ro, tbl[i].e_rin, tbl[i].e_v,
           tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].e_eol,
           $sformatf("tbl_t%0d_i%0d", tbl[i].tid, i));
    end

`ifndef ZERO_PAD_EN
    // Backpressure: ready_out low for 3 cycles after the first window.
    step(0, 1,  0, 1, 1, 0, -1, -1, -1, 0, "t3_c0");
    step(0, 1,  1, 1, 1, 0, -1, -1, -1, 0, "t3_c1");
    step(0, 1,  2, 1, 1, 0, -1, -1, -1, 0, "t3_c2");
    step(0, 1,  3, 0, 0, 1,  0,  1,  2, 0, "t3_hold0");
    step(0, 1,  3, 0, 0, 1,  0,  1,  2, 0, "t3_hold1");
    step(0, 1,  3, 0, 0, 1,  0,  1,  2, 0, "t3_hold2");
    step(0, 1,  3, 1, 1, 1,  0,  1,  2, 0, "t3_release");
    step(0, 1,  4, 1, 1, 1,  1,  2,  3, 0, "t3_c4");
    step(0, 1,  5, 1, 1, 1,  2,  3,  4, 0, "t3_c5");
    step(0, 1,  6, 1, 1, 1,  3,  4,  5, 0, "t3_c6");
    step(0, 1,  7, 1, 1, 1,  4,  5,  6, 0, "t3_c7");
    step(0, 0, -1, 1, 0, 1,  5,  6,  7, 1, "t3_eol");
    step(0, 0, -1, 1, 1, 0, -1, -1, -1, 0, "t3_idle");

    // Reset after column 4 of a row, then a full clean row.
    step(0, 1, 0, 1, 1, 0, -1, -1, -1, 0, "t6_c0");
    step(0, 1, 1, 1, 1, 0, -1, -1, -1, 0, "t6_c1");
    step(0, 1, 2, 1, 1, 0, -1, -1, -1, 0, "t6_c2");
    step(0, 1, 3, 1, 1, 1,  0,  1,  2, 0, "t6_c3");
    step(0, 1, 4, 1, 1, 1,  1,  2,  3, 0, "t6_c4");
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    check_cleared("t6_mid_row_reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 10; j++) begin
      step(0, (j < 8) ? 1 : 0, (j < 8) ? j : -1, 1, (j != 8) ? 1 : 0,
           (j >= 3 && j <= 8) ? 1 : 0, j - 3, j - 2, j - 1, (j == 8) ? 1 : 0,
           $sformatf("t6_row_s%0d", j));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
